// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the EX/MEM/WB stage block:
//               NOP encoding, memory-access FSM states, default datapath
//               width and timeout counter width.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int          DW_DEF    = 16;
    localparam logic [15:0] NOP_INSTR = 16'hB000;
    localparam int          ERR_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_handshake_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_handshake_fsm
// Description : Data-memory req/rdy sequencer. Holds the access state, drives
//               the request/stall indications and, when MEM_TIMEOUT_EN is
//               defined, aborts an access that waits too long for dm_rdy and
//               raises a sticky error flag.
// Config      : MEM_TIMEOUT_EN (undefined by default: wait forever, no error)
// Revision    : 1.0  initial release
// ============================================================================
module dmem_handshake_fsm
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op_ex_i,   // instruction waiting in EX is a load or store
    input  logic dm_rdy_i,
    output logic busy_o,        // access outstanding; doubles as dm_req
    output logic stall_o,       // hold upstream stages
    output logic mem_err_o      // sticky timeout flag
);

    // The timeout counter must be able to reach TIMEOUT-1.
    if (TIMEOUT < 1 || TIMEOUT > (1 << ERR_CNT_W) - 1) begin : g_timeout_range
        $error("dmem_handshake_fsm: TIMEOUT out of range");
    end

    mem_state_t state_q;
    logic       w_abort;
    logic       w_advance;

`ifdef MEM_TIMEOUT_EN
    localparam logic [ERR_CNT_W-1:0] C_LIMIT = ERR_CNT_W'(TIMEOUT - 1);

    logic [ERR_CNT_W-1:0] cnt_q;
    logic                 err_q;

    // Abort in the TIMEOUT-th waiting cycle so dm_req is high exactly TIMEOUT cycles.
    assign w_abort   = (state_q == BUSY) && !dm_rdy_i && (cnt_q == C_LIMIT);
    assign mem_err_o = err_q;
`else
    assign w_abort   = 1'b0;
    assign mem_err_o = 1'b0;
`endif

    assign busy_o    = (state_q == BUSY);
    assign stall_o   = busy_o && !dm_rdy_i && !w_abort;
    // Any edge without stall lets EX/MEM load, so the next state follows the incoming op;
    // an abort therefore still picks up a memory op that arrives on the same edge.
    assign w_advance = !stall_o;

    // State register plus, when enabled, the wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            if (w_advance) begin
                state_q <= mem_op_ex_i ? BUSY : IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            if (w_advance) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + ERR_CNT_W'(1);
            end
            if (w_abort) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register, data-memory access controller and
//               MEM/WB register. Stalls upstream while a memory access is
//               outstanding and inserts WB bubbles during the wait.
// Config      : MEM_TIMEOUT_EN enables the dm_rdy timeout and mem_err flag
// Revision    : 1.0  initial release
// ============================================================================
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] alu_EX,
    input  logic [DW-1:0] sdata_EX,
    input  logic [3:0]    dst_addr_EX,
    input  logic          we_rf_EX,
    input  logic          we_mem_EX,
    input  logic          re_mem_EX,
    input  logic          wb_sel_EX,
    input  logic          hlt_EX,
    input  logic [15:0]   instr_EX,
    input  logic [DW-1:0] pc_EX,
    output logic          dm_req,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_rdy,
    input  logic [DW-1:0] dm_rdata,
    output logic          stall_mem,
    output logic [DW-1:0] wb_data_WB,
    output logic [3:0]    dst_addr_WB,
    output logic          we_rf_WB,
    output logic          hlt_WB,
    output logic [15:0]   instr_WB,
    output logic [DW-1:0] pc_WB,
    output logic          mem_err
);

    // EX/MEM register
    logic [DW-1:0] alu_q, sdata_q, pc_q;
    logic [3:0]    dst_q;
    logic          we_rf_q, we_mem_q, re_mem_q, wb_sel_q, hlt_q;
    logic [15:0]   instr_q;

    // MEM/WB register and its next-state
    logic [DW-1:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
    logic [3:0]    wb_dst_q, wb_dst_d;
    logic          wb_we_q, wb_we_d, wb_hlt_q, wb_hlt_d;
    logic [15:0]   wb_instr_q, wb_instr_d;

    logic          w_busy;

    dmem_handshake_fsm #(
        .TIMEOUT     (TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_op_ex_i (we_mem_EX | re_mem_EX),
        .dm_rdy_i    (dm_rdy),
        .busy_o      (w_busy),
        .stall_o     (stall_mem),
        .mem_err_o   (mem_err)
    );

    assign dm_req   = w_busy;
    assign dm_we    = we_mem_q;
    assign dm_addr  = alu_q;
    assign dm_wdata = sdata_q;

    // EX/MEM register: advance whenever the memory side is not stalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q    <= '0;
            sdata_q  <= '0;
            pc_q     <= '0;
            dst_q    <= '0;
            we_rf_q  <= 1'b0;
            we_mem_q <= 1'b0;
            re_mem_q <= 1'b0;
            wb_sel_q <= 1'b0;
            hlt_q    <= 1'b0;
            instr_q  <= NOP_INSTR;
        end else if (!stall_mem) begin
            alu_q    <= alu_EX;
            sdata_q  <= sdata_EX;
            pc_q     <= pc_EX;
            dst_q    <= dst_addr_EX;
            we_rf_q  <= we_rf_EX;
            we_mem_q <= we_mem_EX;
            re_mem_q <= re_mem_EX;
            wb_sel_q <= wb_sel_EX;
            hlt_q    <= hlt_EX;
            instr_q  <= instr_EX;
        end
    end

    // MEM/WB next-state: pass the MEM instruction, or a bubble while waiting (or aborting).
    always_comb begin
        wb_data_d  = wb_sel_q ? dm_rdata : alu_q;
        wb_dst_d   = dst_q;
        wb_we_d    = we_rf_q;
        wb_hlt_d   = hlt_q;
        wb_instr_d = instr_q;
        wb_pc_d    = pc_q;
        if (w_busy && !dm_rdy) begin
            wb_data_d  = '0;
            wb_dst_d   = '0;
            wb_we_d    = 1'b0;
            wb_hlt_d   = 1'b0;
            wb_instr_d = NOP_INSTR;
            wb_pc_d    = '0;
        end
    end

    // MEM/WB register: updates every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_q  <= '0;
            wb_dst_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_hlt_q   <= 1'b0;
            wb_instr_q <= NOP_INSTR;
            wb_pc_q    <= '0;
        end else begin
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            wb_we_q    <= wb_we_d;
            wb_hlt_q   <= wb_hlt_d;
            wb_instr_q <= wb_instr_d;
            wb_pc_q    <= wb_pc_d;
        end
    end

    assign wb_data_WB  = wb_data_q;
    assign dst_addr_WB = wb_dst_q;
    assign we_rf_WB    = wb_we_q;
    assign hlt_WB      = wb_hlt_q;
    assign instr_WB    = wb_instr_q;
    assign pc_WB       = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage with a variable-latency
//               memory model and a WB scoreboard. Timeout case runs only when
//               MEM_TIMEOUT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam logic [15:0] NOP = 16'hB000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_EX, sdata_EX, pc_EX, instr_EX;
    logic [3:0]  dst_addr_EX;
    logic        we_rf_EX, we_mem_EX, re_mem_EX, wb_sel_EX, hlt_EX;
    logic        dm_req, dm_we, dm_rdy, stall_mem, we_rf_WB, hlt_WB, mem_err;
    logic [15:0] dm_addr, dm_wdata, dm_rdata, wb_data_WB, instr_WB, pc_WB;
    logic [3:0]  dst_addr_WB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] wb_data;
        logic [3:0]  dst;
        logic        we_rf;
        logic        hlt;
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m;
    logic [15:0] ref_mem [256];
    logic [15:0] mem     [256];
    int          wait_cfg = 0;
    int          mcnt = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .DW          (16),
        .TIMEOUT     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_EX      (alu_EX),
        .sdata_EX    (sdata_EX),
        .dst_addr_EX (dst_addr_EX),
        .we_rf_EX    (we_rf_EX),
        .we_mem_EX   (we_mem_EX),
        .re_mem_EX   (re_mem_EX),
        .wb_sel_EX   (wb_sel_EX),
        .hlt_EX      (hlt_EX),
        .instr_EX    (instr_EX),
        .pc_EX       (pc_EX),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdy      (dm_rdy),
        .dm_rdata    (dm_rdata),
        .stall_mem   (stall_mem),
        .wb_data_WB  (wb_data_WB),
        .dst_addr_WB (dst_addr_WB),
        .we_rf_WB    (we_rf_WB),
        .hlt_WB      (hlt_WB),
        .instr_WB    (instr_WB),
        .pc_WB       (pc_WB),
        .mem_err     (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: answers after wait_cfg cycles of dm_req, driven at negedge.
    always @(negedge clk) begin
        if (!rst && dm_req && (mcnt >= wait_cfg)) begin
            dm_rdy   <= 1'b1;
            dm_rdata <= mem[dm_addr[7:0]];
        end else begin
            dm_rdy   <= 1'b0;
            dm_rdata <= 16'h0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mcnt          <= 0;
            mem[8'h40]    <= 16'hBEEF;
        end else if (!dm_req) begin
            mcnt <= 0;
        end else if (dm_rdy) begin
            if (dm_we) mem[dm_addr[7:0]] <= dm_wdata;
            mcnt <= 0;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    // WB monitor: every non-NOP instruction reaching WB is compared against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst !== 1'b1 && instr_WB !== NOP) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {16'h0, instr_WB}, 32'h0);
            end else begin
                m = sb.pop_front();
                chk("sb_instr",   instr_WB,    m.instr);
                chk("sb_wb_data", wb_data_WB,  m.wb_data);
                chk("sb_dst",     dst_addr_WB, m.dst);
                chk("sb_we_rf",   we_rf_WB,    m.we_rf);
                chk("sb_hlt",     hlt_WB,      m.hlt);
                chk("sb_pc",      pc_WB,       m.pc);
            end
        end
    end

    task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] dst,
                         input logic wrf, input logic wm, input logic rm, input logic ws,
                         input logic h, input logic [15:0] ins, input logic [15:0] pcv);
        alu_EX = alu; sdata_EX = sd; dst_addr_EX = dst; we_rf_EX = wrf; we_mem_EX = wm;
        re_mem_EX = rm; wb_sel_EX = ws; hlt_EX = h; instr_EX = ins; pc_EX = pcv;
    endtask

    task automatic nop();
        drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 16'h0);
    endtask

    // Present an instruction in EX and return just after the edge that accepts it.
    task automatic issue(input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] dst,
                         input logic wrf, input logic wm, input logic rm, input logic ws,
                         input logic h, input logic [15:0] ins, input logic [15:0] pcv,
                         input bit push, output int stalls);
        exp_t e;
        logic st;
        drive(alu, sd, dst, wrf, wm, rm, ws, h, ins, pcv);
        if (push) begin
            e.wb_data = ws ? ref_mem[alu[7:0]] : alu;
            e.dst = dst; e.we_rf = wrf; e.hlt = h; e.instr = ins; e.pc = pcv;
            if (wm) ref_mem[alu[7:0]] = sd;
            sb.push_back(e);
        end
        stalls = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk); #2;
            st = stall_mem;
            @(posedge clk); #1;
            if (st !== 1'b1) break;
            stalls++;
        end
        if (stalls >= 100) chk("issue_timeout", 32'(stalls), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, st_sum, lat, stalls, bubbles, reqs;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        ref_mem[8'h40] = 16'hBEEF;
        nop();

        // 1. Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_wb_data", wb_data_WB, 16'h0);
        chk("rst_dst",     dst_addr_WB, 4'h0);
        chk("rst_we_rf",   we_rf_WB, 1'b0);
        chk("rst_hlt",     hlt_WB, 1'b0);
        chk("rst_instr",   instr_WB, 16'hB000);
        chk("rst_pc",      pc_WB, 16'h0);
        chk("rst_dm_req",  dm_req, 1'b0);
        chk("rst_stall",   stall_mem, 1'b0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_dm_addr", dm_addr, 16'h0);

        // 2. ALU ops: two-edge latency, no memory request
        issue(16'h1234, 16'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1001, 16'h0100, 1'b1, st);
        chk("alu_dm_req_mem", dm_req, 1'b0);
        issue(16'hA5A5, 16'h0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1002, 16'h0102, 1'b1, st);
        chk("alu_lat_instr", instr_WB, 16'h1001);
        chk("alu_lat_data",  wb_data_WB, 16'h1234);
        chk("alu_lat_dst",   dst_addr_WB, 4'h3);
        chk("alu_lat_we",    we_rf_WB, 1'b1);
        chk("alu_dm_req",    dm_req, 1'b0);
        nop();
        @(posedge clk); #1;
        chk("alu_hlt_wb",    hlt_WB, 1'b1);
        chk("alu_dm_req2",   dm_req, 1'b0);
        @(posedge clk); #1;

        // 3. Load with three wait cycles
        wait_cfg = 3;
        issue(16'h0040, 16'h0, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3003, 16'h0300, 1'b1, st);
        nop();
        stalls = 0; lat = 0; bubbles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (stall_mem === 1'b1) stalls++;
            @(posedge clk); #1;
            lat++;
            if (instr_WB === 16'h3003) break;
            if (instr_WB === NOP && we_rf_WB === 1'b0) bubbles++;
        end
        chk("ld_stalls",  32'(stalls), 32'd3);
        chk("ld_latency", 32'(lat), 32'd4);
        chk("ld_bubbles", 32'(bubbles), 32'd3);
        chk("ld_data",    wb_data_WB, 16'hBEEF);
        @(posedge clk); #1;

        // 4. Back-to-back store and load, memory ready immediately
        wait_cfg = 0;
        issue(16'h0010, 16'h55AA, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2002, 16'h0200, 1'b1, st);
        st_sum = st;
        chk("b2b_req_st",  dm_req, 1'b1);
        chk("b2b_we_st",   dm_we, 1'b1);
        chk("b2b_wdata",   dm_wdata, 16'h55AA);
        issue(16'h0010, 16'h0, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2003, 16'h0202, 1'b1, st);
        st_sum += st;
        chk("b2b_req_ld",  dm_req, 1'b1);
        chk("b2b_we_ld",   dm_we, 1'b0);
        nop();
        @(negedge clk); #2;
        chk("b2b_stall",   32'(st_sum) | {31'h0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_ld_instr", instr_WB, 16'h2003);
        chk("b2b_ld_data",  wb_data_WB, 16'h55AA);
        chk("b2b_req_end",  dm_req, 1'b0);
        @(posedge clk); #1;

        // 5. Reset while an access is outstanding
        wait_cfg = 1000;
        issue(16'h0040, 16'h0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3004, 16'h0400, 1'b0, st);
        nop();
        chk("busy_req", dm_req, 1'b1);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstb_dm_req", dm_req, 1'b0);
        chk("rstb_stall",  stall_mem, 1'b0);
        chk("rstb_we_rf",  we_rf_WB, 1'b0);
        chk("rstb_instr",  instr_WB, 16'hB000);
        chk("rstb_data",   wb_data_WB, 16'h0);
        chk("rstb_dst",    dst_addr_WB, 4'h0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        // 6. Timeout: dm_rdy never arrives
        issue(16'h0040, 16'h0, 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4005, 16'h0500, 1'b0, st);
        nop();
        reqs = 0; stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (dm_req !== 1'b1) break;
            reqs++;
            if (stall_mem === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        chk("to_req_cycles", 32'(reqs), 32'd4);
        chk("to_stalls",     32'(stalls), 32'd3);
        chk("to_mem_err",    mem_err, 1'b1);
        chk("to_stall_rel",  stall_mem, 1'b0);
        chk("to_bubble_ins", instr_WB, 16'hB000);
        chk("to_bubble_we",  we_rf_WB, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_err_sticky", mem_err, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("to_err_clear",  mem_err, 1'b0);
`else
        chk("no_to_mem_err", mem_err, 1'b0);
`endif
        wait_cfg = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
